// File: rtl/uart_arb_pkg.sv
// Shared types and round-robin pick function for the UART TX arbiter.
package uart_arb_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned LAST_W  = 3;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // Unused upper lanes must be zero; they are then skipped, so a mod-MAX_REQ
  // search visits the real requesters in the same order as a mod-NUM_REQ one.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [LAST_W-1:0]  last);
    logic [MAX_REQ-1:0] pick;
    logic [LAST_W-1:0]  idx;
    pick = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = LAST_W'(32'(last) + k);
      if (pick == '0 && valid[idx]) pick[idx] = 1'b1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_pick.sv
// Combinational round-robin rotate-and-priority-encode: one-hot pick plus its index.
module rr_priority_pick
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx
);

  assign pick = NUM_REQ'(rr_pick(MAX_REQ'(valid), LAST_W'(last)));

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-based round-robin arbiter feeding the UART TX FIFO write port.
// Optional stall-release timeout is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned FIFO_DEPTH = 16,
  parameter  int unsigned TIMEOUT    = 64,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1,
  localparam int unsigned IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [CNT_W-1:0]              tx_fifo_cnt,
  output logic [DATA_WIDTH-1:0]         tx_din,
  output logic                          wr_uart,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          timeout_evt
);

  arb_state_t              state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic                    wr_q, wr_d;

  logic [NUM_REQ-1:0]      pick;
  logic [IDX_W-1:0]        pick_idx;
  logic                    own_valid, own_last, space, xfer, timeout_rel;
  logic [DATA_WIDTH-1:0]   own_byte;
  logic [CNT_W:0]          occ;

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid    (req_valid),
    .last     (last_q),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  // Owner's lane selected through the one-hot grant.
  always_comb begin
    own_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) own_byte = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign own_valid = |(req_valid & grant_q);
  assign own_last  = |(req_last & grant_q);
  // Count the write still in flight so the FIFO never overfills.
  assign occ       = {1'b0, tx_fifo_cnt} + (CNT_W+1)'(wr_q);
  assign space     = occ < (CNT_W+1)'(FIFO_DEPTH);
  assign xfer      = (state_q == GRANT) && own_valid && space;
  assign req_ready = (state_q == GRANT && space) ? grant_q : '0;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic            evt_q;

  always_comb begin
    tcnt_d      = tcnt_q;
    timeout_rel = 1'b0;
    if (state_q == GRANT) begin
      if (xfer) begin
        tcnt_d = '0;
      end else if (!own_valid) begin
        if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
          timeout_rel = 1'b1;
          tcnt_d      = '0;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
      evt_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      evt_q  <= timeout_rel;
    end
  end

  assign timeout_evt = evt_q;
`else
  // TIMEOUT has no effect without the stall-release counter.
  localparam logic TO_TIE = (TIMEOUT == 0) && 1'b0;

  assign timeout_rel = 1'b0;
  assign timeout_evt = TO_TIE;
`endif

  // Next-state and output register inputs.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    din_d   = din_q;
    wr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = GRANT;
          grant_d = pick;
          owner_d = pick_idx;
        end
      end
      GRANT: begin
        if (xfer) begin
          din_d = own_byte;
          wr_d  = 1'b1;
        end
        if ((xfer && own_last) || timeout_rel) begin
          last_d  = owner_q;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      din_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
    end
  end

  assign grant   = grant_q;
  assign tx_din  = din_q;
  assign wr_uart = wr_q;
  assign busy    = (state_q == GRANT);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (4 requesters, 16-deep FIFO, TIMEOUT 8).
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic [4:0]    tx_fifo_cnt;
  logic [DW-1:0] tx_din;
  logic          wr_uart;
  logic [NR-1:0] grant;
  logic          busy;
  logic          timeout_evt;

  int vectors = 0;
  int errors  = 0;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_DEPTH(16), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_fifo_cnt (tx_fifo_cnt),
    .tx_din      (tx_din),
    .wr_uart     (wr_uart),
    .grant       (grant),
    .busy        (busy),
    .timeout_evt (timeout_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i]       = v;
    req_data[i*DW +: DW] = d;
    req_last[i]        = l;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_fifo_cnt = '0;
    tick(); tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr", 32'(wr_uart), 0);
    chk("rst_din", 32'(tx_din), 0);
    chk("rst_evt", 32'(timeout_evt), 0);
    chk("rst_ready", 32'(req_ready), 0);
    rst = 1'b0;

    // Three-byte message from requester 0
    set_req(0, 1'b1, 8'h11, 1'b0); #1;
    chk("t1_idle_ready", 32'(req_ready), 0);
    tick();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_ready", 32'(req_ready), 32'h1);
    tick();
    chk("t1_wr0", 32'(wr_uart), 1); chk("t1_din0", 32'(tx_din), 32'h11);
    set_req(0, 1'b1, 8'h22, 1'b0);
    tick();
    chk("t1_wr1", 32'(wr_uart), 1); chk("t1_din1", 32'(tx_din), 32'h22);
    set_req(0, 1'b1, 8'h33, 1'b1);
    tick();
    chk("t1_wr2", 32'(wr_uart), 1); chk("t1_din2", 32'(tx_din), 32'h33);
    chk("t1_release", 32'(grant), 0); chk("t1_idle", 32'(busy), 0);
    set_req(0, 1'b0, 8'h00, 1'b0);
    tick();
    chk("t1_wr_end", 32'(wr_uart), 0); chk("t1_din_hold", 32'(tx_din), 32'h33);

    // Round robin from reset: 0,1,2,3,0 with a bubble between messages
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(8'hC0 + i), 1'b1);
    for (int m = 0; m < 5; m++) begin
      tick();
      chk("rr_grant", 32'(grant), 32'(1 << (m % 4)));
      chk("rr_bubble", 32'(wr_uart), 0);
      tick();
      chk("rr_wr", 32'(wr_uart), 1);
      chk("rr_din", 32'(tx_din), 32'(8'hC0 + (m % 4)));
      chk("rr_release", 32'(grant), 0);
      if (m == 4) begin req_valid = '0; req_last = '0; end
    end
    tick();
    chk("rr_quiet", 32'(wr_uart), 0);

    // No interleave: requester 1 two bytes, then requester 2
    set_req(1, 1'b1, 8'hA0, 1'b0); set_req(2, 1'b1, 8'hB0, 1'b1);
    tick();
    chk("ni_grant1", 32'(grant), 32'h2);
    tick();
    chk("ni_din_a0", 32'(tx_din), 32'hA0);
    set_req(1, 1'b1, 8'hA1, 1'b1);
    tick();
    chk("ni_din_a1", 32'(tx_din), 32'hA1); chk("ni_wr_a1", 32'(wr_uart), 1);
    set_req(1, 1'b0, 8'h00, 1'b0);
    tick();
    chk("ni_grant2", 32'(grant), 32'h4); chk("ni_bubble", 32'(wr_uart), 0);
    tick();
    chk("ni_din_b0", 32'(tx_din), 32'hB0); chk("ni_wr_b0", 32'(wr_uart), 1);
    set_req(2, 1'b0, 8'h00, 1'b0);
    tick();
    chk("ni_quiet", 32'(wr_uart), 0);

    // Full FIFO back-pressure
    tx_fifo_cnt = 5'd15; set_req(3, 1'b1, 8'h5A, 1'b0);
    tick();
    chk("ff_grant", 32'(grant), 32'h8);
    chk("ff_ready_space", 32'(req_ready), 32'h8);
    tick();
    chk("ff_wr", 32'(wr_uart), 1); chk("ff_din", 32'(tx_din), 32'h5A);
    chk("ff_ready_inflight", 32'(req_ready), 0);
    tx_fifo_cnt = 5'd16;
    tick();
    chk("ff_ready_full0", 32'(req_ready), 0); chk("ff_no_wr0", 32'(wr_uart), 0);
    tick();
    chk("ff_ready_full1", 32'(req_ready), 0); chk("ff_no_wr1", 32'(wr_uart), 0);
    tx_fifo_cnt = 5'd14; #1;
    chk("ff_ready_drain", 32'(req_ready), 32'h8);
    set_req(3, 1'b1, 8'h5B, 1'b1);
    tick();
    chk("ff_wr_5b", 32'(wr_uart), 1); chk("ff_din_5b", 32'(tx_din), 32'h5B);
    tx_fifo_cnt = '0; set_req(3, 1'b0, 8'h00, 1'b0);

    // Reset mid-message restores last_grant so requester 0 wins
    set_req(2, 1'b1, 8'hE0, 1'b1);
    tick();
    chk("mr_grant2", 32'(grant), 32'h4);
    tick();
    chk("mr_din_e0", 32'(tx_din), 32'hE0);
    set_req(2, 1'b0, 8'h00, 1'b0); set_req(1, 1'b1, 8'hD0, 1'b0);
    tick();
    chk("mr_grant1", 32'(grant), 32'h2);
    tick();
    chk("mr_din_d0", 32'(tx_din), 32'hD0);
    set_req(1, 1'b1, 8'hD1, 1'b0);
    tick();
    chk("mr_din_d1", 32'(tx_din), 32'hD1);
    set_req(1, 1'b1, 8'hD2, 1'b0); rst = 1'b1;
    tick();
    chk("mr_grant", 32'(grant), 0); chk("mr_busy", 32'(busy), 0);
    chk("mr_wr", 32'(wr_uart), 0); chk("mr_din", 32'(tx_din), 0);
    chk("mr_evt", 32'(timeout_evt), 0); chk("mr_ready", 32'(req_ready), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(8'hF0 + i), 1'b1);
    tick();
    chk("mr_next_grant", 32'(grant), 32'h1);
    tick();
    chk("mr_din_f0", 32'(tx_din), 32'hF0);
    req_valid = '0; req_last = '0;

    // Owner stalls after one byte
    set_req(3, 1'b1, 8'h77, 1'b0);
    tick();
    chk("to_grant3", 32'(grant), 32'h8);
    tick();
    chk("to_din_77", 32'(tx_din), 32'h77);
    set_req(3, 1'b0, 8'h00, 1'b0); set_req(0, 1'b1, 8'h88, 1'b1);
    for (int t = 1; t <= 7; t++) begin
      tick();
      chk("to_evt_quiet", 32'(timeout_evt), 0);
      chk("to_hold", 32'(grant), 32'h8);
    end
    tick();
`ifdef UART_ARB_TIMEOUT_EN
    chk("to_evt_pulse", 32'(timeout_evt), 1);
    chk("to_released", 32'(grant), 0);
    tick();
    chk("to_evt_once", 32'(timeout_evt), 0);
    chk("to_next_grant", 32'(grant), 32'h1);
`else
    chk("to_evt_tied", 32'(timeout_evt), 0);
    chk("to_still_held", 32'(grant), 32'h8);
    tick();
    chk("to_evt_tied2", 32'(timeout_evt), 0);
    chk("to_still_held2", 32'(grant), 32'h8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
